// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard / stall / flush controller.
//
// Resolves hazards in one priority chain, highest first:
//   1. MEM wait        2. flush (new or pending)
//   3. EX busy         4. load-use         5. none
// All stall/flush outputs are combinational from the state and the current inputs.
// A flush requested while MEM is waiting is remembered in FLUSH_PEND.
// It is then applied once, in the first cycle with mem_ready_i=1.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build a saturating 32-bit
// counter of cycles with stall_if_o=1. Without it, stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_rreq_i  [RP]          per-port ID read request
//   id_raddr_i [RP*5]        per-port ID read address (port i at [i*5 +: 5])
//   ex_we_i, ex_is_load_i    EX writes a register / EX is a load
//   ex_waddr_i [5]           EX destination register
//   ex_busy_i                EX multi-cycle unit not finished
//   mem_ready_i              MEM stage can accept/retire this cycle
//   flush_req_i              single-cycle flush request from MEM
//   stall_{if,id,ex,mem}_o   hold the named pipeline register
//   flush_{id,ex,mem}_o      load a bubble into the named pipeline register
//   stall_cnt_o [32]         cycles with stall_if_o=1 (0 without the macro)
module hazard_ctrl #(
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [READ_PORTS-1:0]     id_rreq_i,
    input  logic [READ_PORTS*5-1:0]   id_raddr_i,
    input  logic                      ex_we_i,
    input  logic                      ex_is_load_i,
    input  logic [4:0]                ex_waddr_i,
    input  logic                      ex_busy_i,
    input  logic                      mem_ready_i,
    input  logic                      flush_req_i,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      stall_ex_o,
    output logic                      stall_mem_o,
    output logic                      flush_id_o,
    output logic                      flush_ex_o,
    output logic                      flush_mem_o,
    output logic [31:0]               stall_cnt_o
);

    localparam int unsigned AddrW = 5;
    localparam int unsigned CntW  = 32;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        FLUSH_PEND = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   hit;
    logic   load_use;
    logic   flush_now;

    // ID read port matches the EX destination; r0 never hits
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(READ_PORTS); i++) begin
            if (id_rreq_i[i] && ex_we_i &&
                (id_raddr_i[i*AddrW +: AddrW] != AddrW'(0)) &&
                (id_raddr_i[i*AddrW +: AddrW] == ex_waddr_i)) begin
                hit = 1'b1;
            end
        end
    end

    // A non-load hit is resolved by EX forwarding and needs no stall
    assign load_use  = hit && ex_is_load_i;
    assign flush_now = flush_req_i || (state_q == FLUSH_PEND);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: hold the flush across MEM wait cycles; a new request merges with a pending one
    always_comb begin
        state_d = IDLE;
        if (!mem_ready_i && flush_now) begin
            state_d = FLUSH_PEND;
        end
    end

    // Outputs: priority chain
    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_mem_o = 1'b0;
        if (rst_i) begin
            // all outputs held at 0 during reset
        end else if (!mem_ready_i) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
        end else if (flush_now) begin
            flush_id_o  = 1'b1;
            flush_ex_o  = 1'b1;
            flush_mem_o = 1'b1;
        end else if (ex_busy_i) begin
            // EX holds; bubble into MEM since nothing leaves EX
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            flush_mem_o = 1'b1;
        end else if (load_use) begin
            // one bubble: the load advances to MEM and is then forwardable
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            flush_ex_o  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturating count of cycles with stall_if_o=1
    always_comb begin
        cnt_d = cnt_q;
        if (stall_if_o && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;
`else
    assign stall_cnt_o = CntW'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// Expected outputs are packed as {sif,sid,sex,smem,fid,fex,fmem}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  id_rreq;
    logic [9:0]  id_raddr;
    logic        ex_we, ex_is_load, ex_busy, mem_ready, flush_req;
    logic [4:0]  ex_waddr;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem;
    logic [31:0] stall_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cnt_exp = 32'd0;

    localparam logic [6:0] NONE  = 7'b000_0000;
    localparam logic [6:0] LDUSE = 7'b1100_010;
    localparam logic [6:0] BUSY  = 7'b1110_001;
    localparam logic [6:0] MWAIT = 7'b1111_000;
    localparam logic [6:0] FLUSH = 7'b0000_111;

    always #5 clk = ~clk;

    hazard_ctrl #(.READ_PORTS(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .id_rreq_i    (id_rreq),
        .id_raddr_i   (id_raddr),
        .ex_we_i      (ex_we),
        .ex_is_load_i (ex_is_load),
        .ex_waddr_i   (ex_waddr),
        .ex_busy_i    (ex_busy),
        .mem_ready_i  (mem_ready),
        .flush_req_i  (flush_req),
        .stall_if_o   (stall_if),
        .stall_id_o   (stall_id),
        .stall_ex_o   (stall_ex),
        .stall_mem_o  (stall_mem),
        .flush_id_o   (flush_id),
        .flush_ex_o   (flush_ex),
        .flush_mem_o  (flush_mem),
        .stall_cnt_o  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the combinational outputs for the current inputs, then advance one clock
    task automatic step(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, 32'({stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem}),
            32'(exp));
        @(posedge clk);
        if (PERF && !rst && exp[6]) cnt_exp = cnt_exp + 32'd1;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_rreq = 2'b00; id_raddr = 10'd0;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 5'd0;
        ex_busy = 1'b0; mem_ready = 1'b1; flush_req = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // reset with a load-use hazard and MEM wait present: outputs stay 0
        rst = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5;
        id_rreq = 2'b10; id_raddr = {5'd5, 5'd0}; mem_ready = 1'b0;
        step("reset_outs", NONE);
        idle_inputs();
        chk("reset_cnt", stall_cnt, 32'd0);
        step("idle", NONE);

        // load-use on port 1, then the load leaves EX
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd5;
        id_rreq = 2'b10; id_raddr = {5'd5, 5'd0};
        step("ld_use_p1", LDUSE);
        ex_we = 1'b0;
        step("ld_gone", NONE);

        // r0 never hits
        ex_we = 1'b1; ex_waddr = 5'd0; id_raddr = {5'd0, 5'd0};
        step("r0_nohit", NONE);
        // non-load hit is forwarded
        ex_is_load = 1'b0; ex_waddr = 5'd5; id_raddr = {5'd5, 5'd0};
        step("alu_hit", NONE);
        // load-use on port 0
        ex_is_load = 1'b1; ex_waddr = 5'd17; id_rreq = 2'b01; id_raddr = {5'd3, 5'd17};
        step("ld_use_p0", LDUSE);
        // address match but no read request
        id_rreq = 2'b10;
        step("no_rreq", NONE);
        idle_inputs();
        chk("cnt_after_ld", stall_cnt, cnt_exp);

        // EX busy for 4 cycles
        ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("ex_busy", BUSY);
        ex_busy = 1'b0;
        step("busy_done", NONE);
        chk("cnt_after_busy", stall_cnt, cnt_exp);

        // MEM wait 3 cycles, flush requested in cycle 1 -> one flush afterwards
        mem_ready = 1'b0; flush_req = 1'b1;
        step("mwait1", MWAIT);
        flush_req = 1'b0;
        step("mwait2", MWAIT);
        step("mwait3", MWAIT);
        mem_ready = 1'b1;
        step("pend_flush", FLUSH);
        step("after_flush", NONE);
        chk("cnt_after_mwait", stall_cnt, cnt_exp);

        // two requests during the wait merge into a single flush
        mem_ready = 1'b0; flush_req = 1'b1;
        step("merge_w1", MWAIT);
        step("merge_w2", MWAIT);
        flush_req = 1'b0;
        step("merge_w3", MWAIT);
        mem_ready = 1'b1;
        step("merge_flush", FLUSH);
        step("merge_once", NONE);

        // pending flush dropped by reset
        mem_ready = 1'b0; flush_req = 1'b1;
        step("pend_mk", MWAIT);
        flush_req = 1'b0;
        step("pend_hold", MWAIT);
        rst = 1'b1;
        step("pend_rst", NONE);
        rst = 1'b0; mem_ready = 1'b1;
        cnt_exp = 32'd0;
        chk("rst_cnt_zero", stall_cnt, 32'd0);
        step("no_flush_post_rst", NONE);
        step("no_flush_post_rst2", NONE);

        // flush beats EX busy and load-use
        flush_req = 1'b1; ex_busy = 1'b1;
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd9; id_rreq = 2'b11; id_raddr = {5'd9, 5'd9};
        step("flush_prio", FLUSH);
        flush_req = 1'b0;
        step("busy_over_ld", BUSY);
        ex_busy = 1'b0;
        step("ld_after_busy", LDUSE);
        idle_inputs();
        step("final_idle", NONE);
        chk("cnt_final", stall_cnt, cnt_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
